// File: rtl/enemy_formation_pkg.sv
// Shared types and geometry constants for the enemy formation.
// Cell pitch = sprite size plus the gap to the next sprite.
package enemy_formation_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MARCH_R,
    MARCH_L,
    CLEAR,
    LANDED
  } formation_state_t;

  localparam int DEF_ENEMY_W   = 32;
  localparam int DEF_ENEMY_H   = 28;
  localparam int DEF_SPACING_X = 50;
  localparam int DEF_SPACING_Y = 16;

  localparam int PITCH_X = DEF_ENEMY_W + DEF_SPACING_X;
  localparam int PITCH_Y = DEF_ENEMY_H + DEF_SPACING_Y;

  localparam int COORD_W = 12;

  function automatic int pitch(input int size, input int gap);
    return size + gap;
  endfunction

endpackage

// File: rtl/enemy_cell_lookup.sv
// Maps a pixel offset from the grid origin to (row, col, in_cell)
// with one range compare per column and per row.
module enemy_cell_lookup
  import enemy_formation_pkg::*;
#(
  parameter int NUM_ROWS = 10,
  parameter int NUM_COLS = 6,
  parameter int ENEMY_W  = DEF_ENEMY_W,
  parameter int ENEMY_H  = DEF_ENEMY_H,
  parameter int PX       = PITCH_X,
  parameter int PY       = PITCH_Y,
  parameter int RW       = $clog2(NUM_ROWS),
  parameter int CW       = $clog2(NUM_COLS)
) (
  input  logic [COORD_W-1:0] dx,
  input  logic [COORD_W-1:0] dy,
  output logic [RW-1:0]      row,
  output logic [CW-1:0]      col,
  output logic               in_cell
);

  logic in_x;
  logic in_y;
  logic [COORD_W-1:0] lo_x;
  logic [COORD_W-1:0] lo_y;

  always_comb begin
    col  = '0;
    in_x = 1'b0;
    lo_x = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      lo_x = COORD_W'(c * PX);
      if (dx >= lo_x && dx < lo_x + COORD_W'(ENEMY_W)) begin
        in_x = 1'b1;
        col  = CW'(c);
      end
    end
  end

  always_comb begin
    row  = '0;
    in_y = 1'b0;
    lo_y = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      lo_y = COORD_W'(r * PY);
      if (dy >= lo_y && dy < lo_y + COORD_W'(ENEMY_H)) begin
        in_y = 1'b1;
        row  = RW'(r);
      end
    end
  end

  assign in_cell = in_x & in_y;

endmodule

// File: rtl/enemy_formation.sv
// Enemy grid controller: alive bitmap, origin, march FSM, hits, pixel query.
// Define ENEMY_SPEEDUP_EN to speed the march up as aliens are killed.
module enemy_formation
  import enemy_formation_pkg::*;
#(
  parameter int NUM_COLS      = 6,
  parameter int NUM_ROWS      = 10,
  parameter int ENEMY_W       = DEF_ENEMY_W,
  parameter int ENEMY_H       = DEF_ENEMY_H,
  parameter int SPACING_X     = DEF_SPACING_X,
  parameter int SPACING_Y     = DEF_SPACING_Y,
  parameter int HRES          = 1280,
  parameter int VRES          = 720,
  parameter int HSTART        = 419,
  parameter int VSTART        = 108,
  parameter int DROP          = 32,
  parameter int BASE_SPEED    = 1,
  parameter int BOTTOM_LIMIT  = 684,
  parameter int SPEEDUP_SHIFT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic start,
  input  logic hit_valid,
  input  logic [$clog2(NUM_ROWS)-1:0] hit_row,
  input  logic [$clog2(NUM_COLS)-1:0] hit_col,
  output logic hit_ack,
  input  logic [10:0] pix_x,
  input  logic [9:0]  pix_y,
  output logic enemy_on,
  output logic [$clog2(NUM_ROWS)-1:0] enemy_row,
  output logic [$clog2(NUM_COLS)-1:0] enemy_col,
  output logic [10:0] origin_x,
  output logic [9:0]  origin_y,
  output logic [NUM_ROWS*NUM_COLS-1:0] alive,
  output logic [$clog2(NUM_ROWS*NUM_COLS+1)-1:0] alive_count,
  output logic wave_clear,
  output logic landed
);

  localparam int N  = NUM_ROWS * NUM_COLS;
  localparam int RW = $clog2(NUM_ROWS);
  localparam int CW = $clog2(NUM_COLS);
  localparam int NW = $clog2(N + 1);
  localparam int PX = pitch(ENEMY_W, SPACING_X);
  localparam int PY = pitch(ENEMY_H, SPACING_Y);
  localparam int XW = COORD_W;

  formation_state_t state;

  logic [NUM_COLS-1:0] col_live;
  logic [NUM_ROWS-1:0] row_live;
  logic [CW-1:0] min_col, max_col;
  logic [RW-1:0] max_row;
  logic [N-1:0]  hit_mask;

  logic [XW-1:0] x12, y12, speed;
  logic [XW-1:0] left_e, right_e, y_drop, bottom_e;
  logic at_right, at_left, drop, lands;
  logic marching, take_hit, last_kill;

  logic [XW-1:0] dx, dy;
  logic px_ge, py_ge;
  logic [RW-1:0] look_row;
  logic [CW-1:0] look_col;
  logic look_in;

  function automatic logic cell_alive(
    input logic [N-1:0]  v,
    input logic [RW-1:0] r,
    input logic [CW-1:0] c
  );
    cell_alive = 1'b0;
    for (int i = 0; i < NUM_ROWS; i++)
      for (int j = 0; j < NUM_COLS; j++)
        if (r == RW'(i) && c == CW'(j))
          cell_alive = v[i*NUM_COLS+j];
  endfunction

  always_comb begin
    col_live = '0;
    row_live = '0;
    for (int r = 0; r < NUM_ROWS; r++)
      for (int c = 0; c < NUM_COLS; c++)
        if (alive[r*NUM_COLS+c]) begin
          col_live[c] = 1'b1;
          row_live[r] = 1'b1;
        end
  end

  always_comb begin
    min_col = '0;
    max_col = '0;
    max_row = '0;
    for (int c = NUM_COLS - 1; c >= 0; c--)
      if (col_live[c]) min_col = CW'(c);
    for (int c = 0; c < NUM_COLS; c++)
      if (col_live[c]) max_col = CW'(c);
    for (int r = 0; r < NUM_ROWS; r++)
      if (row_live[r]) max_row = RW'(r);
  end

`ifdef ENEMY_SPEEDUP_EN
  logic [XW-1:0] boost;
  always_comb begin
    boost = (XW'(N) - XW'(alive_count)) >> SPEEDUP_SHIFT;
    speed = XW'(BASE_SPEED) + boost;
    if (speed > XW'(15)) speed = XW'(15);
  end
`else
  assign speed = XW'(BASE_SPEED);
`endif

  assign x12      = {1'b0, origin_x};
  assign y12      = {2'b0, origin_y};
  assign left_e   = x12 + XW'(PX) * XW'(min_col);
  assign right_e  = x12 + XW'(PX) * XW'(max_col)
                  + XW'(ENEMY_W - 1);
  assign y_drop   = y12 + XW'(DROP);
  assign bottom_e = y_drop + XW'(PY) * XW'(max_row)
                  + XW'(ENEMY_H);

  // reverse before the last sprite column reaches the final pixel
  assign at_right = right_e + speed >= XW'(HRES - 1);
  assign at_left  = left_e < speed;
  assign drop     = (state == MARCH_R) ? at_right : at_left;
  assign lands    = bottom_e >= XW'(BOTTOM_LIMIT);

  always_comb begin
    hit_mask = '0;
    for (int r = 0; r < NUM_ROWS; r++)
      for (int c = 0; c < NUM_COLS; c++)
        if (hit_row == RW'(r) && hit_col == CW'(c))
          hit_mask[r*NUM_COLS+c] = 1'b1;
  end

  assign marching  = (state == MARCH_R) || (state == MARCH_L);
  assign take_hit  = marching && hit_valid && |(hit_mask & alive);
  assign last_kill = take_hit && (alive_count == NW'(1));

  assign px_ge = {1'b0, pix_x} >= x12;
  assign py_ge = {2'b0, pix_y} >= y12;
  assign dx    = {1'b0, pix_x} - x12;
  assign dy    = {2'b0, pix_y} - y12;

  enemy_cell_lookup #(
    .NUM_ROWS (NUM_ROWS),
    .NUM_COLS (NUM_COLS),
    .ENEMY_W  (ENEMY_W),
    .ENEMY_H  (ENEMY_H),
    .PX       (PX),
    .PY       (PY),
    .RW       (RW),
    .CW       (CW)
  ) u_lookup (
    .dx      (dx),
    .dy      (dy),
    .row     (look_row),
    .col     (look_col),
    .in_cell (look_in)
  );

  always_ff @(posedge clk) begin
    hit_ack    <= 1'b0;
    wave_clear <= 1'b0;
    enemy_row  <= look_row;
    enemy_col  <= look_col;
    enemy_on   <= (state != IDLE) && px_ge && py_ge && look_in
                && cell_alive(alive, look_row, look_col);
    if (rst) begin
      state       <= IDLE;
      origin_x    <= 11'(HSTART);
      origin_y    <= 10'(VSTART);
      alive       <= '1;
      alive_count <= NW'(N);
      landed      <= 1'b0;
      enemy_on    <= 1'b0;
      enemy_row   <= '0;
      enemy_col   <= '0;
    end else if (start) begin
      state       <= MARCH_R;
      origin_x    <= 11'(HSTART);
      origin_y    <= 10'(VSTART);
      alive       <= '1;
      alive_count <= NW'(N);
      landed      <= 1'b0;
    end else if (marching) begin
      if (frame_tick) begin
        if (drop) begin
          origin_y <= y_drop[9:0];
          state    <= (state == MARCH_R) ? MARCH_L : MARCH_R;
          if (lands) begin
            state  <= LANDED;
            landed <= 1'b1;
          end
        end else if (state == MARCH_R) begin
          origin_x <= origin_x + speed[10:0];
        end else begin
          origin_x <= origin_x - speed[10:0];
        end
      end
      if (take_hit) begin
        alive       <= alive & ~hit_mask;
        alive_count <= alive_count - NW'(1);
        hit_ack     <= 1'b1;
        // clearing the wave outranks a same-cycle landing
        if (last_kill) begin
          wave_clear <= 1'b1;
          state      <= CLEAR;
          landed     <= landed;
        end
      end
    end
  end

endmodule

// File: tb/tb_enemy_formation.sv
// Scoreboard bench for enemy_formation against an arithmetic reference model.
// Honours ENEMY_SPEEDUP_EN the same way the design does.
module tb_enemy_formation;

  localparam int NR = 10;
  localparam int NC = 6;
  localparam int N  = 60;
  localparam int EW = 32;
  localparam int EH = 28;
  localparam int PX = 82;
  localparam int PY = 44;

  localparam int S_IDLE = 0;
  localparam int S_R    = 1;
  localparam int S_L    = 2;
  localparam int S_CLR  = 3;
  localparam int S_LAND = 4;

  logic clk = 1'b0;
  logic rst, frame_tick, start, hit_valid;
  logic [3:0] hit_row;
  logic [2:0] hit_col;
  logic hit_ack;
  logic [10:0] pix_x;
  logic [9:0] pix_y;
  logic enemy_on;
  logic [3:0] enemy_row;
  logic [2:0] enemy_col;
  logic [10:0] origin_x;
  logic [9:0] origin_y;
  logic [59:0] alive;
  logic [5:0] alive_count;
  logic wave_clear, landed;

  always #5 clk = ~clk;

  enemy_formation dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .start       (start),
    .hit_valid   (hit_valid),
    .hit_row     (hit_row),
    .hit_col     (hit_col),
    .hit_ack     (hit_ack),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .enemy_on    (enemy_on),
    .enemy_row   (enemy_row),
    .enemy_col   (enemy_col),
    .origin_x    (origin_x),
    .origin_y    (origin_y),
    .alive       (alive),
    .alive_count (alive_count),
    .wave_clear  (wave_clear),
    .landed      (landed)
  );

  typedef struct {
    int due;
    int ox;
    int oy;
    logic [59:0] al;
    int cnt;
    bit ack;
    bit wc;
    bit ld;
    bit on;
    int row;
    int col;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  int m_st, mox, moy, mcnt;
  bit ma[NR][NC];
  bit mland;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic int spd(input int cnt);
    int s;
`ifdef ENEMY_SPEEDUP_EN
    s = 1 + ((N - cnt) >> 4);
    if (s > 15) s = 15;
`else
    s = 1;
`endif
    return s;
  endfunction

  task automatic model(input bit r, input bit st, input bit tk,
                       input bit hv, input int hr, input int hc,
                       input int px, input int py, output exp_t e);
    int nst, sp, minc, maxc, maxr, dx, dy, cc, rr;
    bit land;
    e.on = 0; e.row = 0; e.col = 0; e.ack = 0; e.wc = 0;
    if (m_st != S_IDLE && px >= mox && py >= moy) begin
      dx = px - mox; dy = py - moy;
      cc = dx / PX;  rr = dy / PY;
      if (cc < NC && rr < NR && dx % PX < EW && dy % PY < EH
          && ma[rr][cc]) begin
        e.on = 1; e.row = rr; e.col = cc;
      end
    end
    if (r || st) begin
      m_st = r ? S_IDLE : S_R;
      mox = 419; moy = 108; mcnt = N; mland = 0;
      foreach (ma[i, j]) ma[i][j] = 1;
      if (r) e.on = 0;
    end else if (m_st == S_R || m_st == S_L) begin
      nst = m_st; land = 0; sp = spd(mcnt);
      if (tk) begin
        minc = NC; maxc = -1; maxr = -1;
        foreach (ma[i, j]) if (ma[i][j]) begin
          if (j < minc) minc = j;
          if (j > maxc) maxc = j;
          if (i > maxr) maxr = i;
        end
        if (m_st == S_R && mox + maxc * PX + EW - 1 + sp >= 1279) begin
          moy += 32; nst = S_L;
          land = (moy + maxr * PY + EH >= 684);
        end else if (m_st == S_L && mox + minc * PX < sp) begin
          moy += 32; nst = S_R;
          land = (moy + maxr * PY + EH >= 684);
        end else if (m_st == S_R) mox += sp;
        else mox -= sp;
      end
      if (hv && hr < NR && hc < NC && ma[hr][hc]) begin
        ma[hr][hc] = 0; mcnt--; e.ack = 1;
        if (mcnt == 0) e.wc = 1;
      end
      if (e.wc) nst = S_CLR;
      else if (land) begin nst = S_LAND; mland = 1; end
      m_st = nst;
    end
    e.ox = mox; e.oy = moy; e.cnt = mcnt; e.ld = mland;
    foreach (ma[i, j]) e.al[i*NC+j] = ma[i][j];
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk("origin_x", 64'(origin_x), 64'(e.ox));
      chk("origin_y", 64'(origin_y), 64'(e.oy));
      chk("alive", 64'(alive), 64'(e.al));
      chk("alive_count", 64'(alive_count), 64'(e.cnt));
      chk("hit_ack", 64'(hit_ack), 64'(e.ack));
      chk("wave_clear", 64'(wave_clear), 64'(e.wc));
      chk("landed", 64'(landed), 64'(e.ld));
      chk("enemy_on", 64'(enemy_on), 64'(e.on));
      if (e.on) begin
        chk("enemy_row", 64'(enemy_row), 64'(e.row));
        chk("enemy_col", 64'(enemy_col), 64'(e.col));
      end
    end
  end

  task automatic op(input bit r, input bit st, input bit tk,
                    input bit hv, input int hr, input int hc,
                    input int qx, input int qy);
    int px, py;
    exp_t e;
    px = qx; py = qy;
    if (qx < 0) begin
      if ($urandom_range(0, 1) == 1) begin
        px = mox + int'($urandom_range(0, 520));
        py = moy + int'($urandom_range(0, 460));
      end else begin
        px = int'($urandom_range(0, 1279));
        py = int'($urandom_range(0, 719));
      end
      if (px > 2047) px = 2047;
      if (py > 1023) py = 1023;
    end
    rst = r; start = st; frame_tick = tk; hit_valid = hv;
    hit_row = hr[3:0]; hit_col = hc[2:0];
    pix_x = px[10:0]; pix_y = py[9:0];
    model(r, st, tk, hv, hr, hc, px, py, e);
    e.due = cyc + 1;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    op(0, 0, 1, 0, 0, 0, -1, -1);
  endtask

  task automatic hit(input int r, input int c);
    op(0, 0, 0, 1, r, c, -1, -1);
  endtask

  task automatic query(input int x, input int y);
    op(0, 0, 0, 0, 0, 0, x, y);
  endtask

  task automatic go();
    op(0, 1, 0, 0, 0, 0, -1, -1);
  endtask

  initial begin
    int guard;
    op(1, 0, 0, 0, 0, 0, -1, -1);
    op(1, 0, 0, 0, 0, 0, -1, -1);
    chk("reset_count", 64'(alive_count), 64'd60);
    repeat (5) tick();
    chk("idle_x", 64'(origin_x), 64'd419);

    go();
    chk("start_count", 64'(alive_count), 64'd60);
    query(419, 108);
    chk("q_cell00", 64'(enemy_on), 64'd1);
    query(451, 108);
    chk("q_gap", 64'(enemy_on), 64'd0);
    hit(0, 5);
    chk("hit_ack", 64'(hit_ack), 64'd1);
    chk("hit_cnt", 64'(alive_count), 64'd59);
    hit(0, 5);
    chk("rehit_ack", 64'(hit_ack), 64'd0);
    chk("rehit_cnt", 64'(alive_count), 64'd59);
    hit(10, 0);
    chk("oor_ack", 64'(hit_ack), 64'd0);
    hit(0, 0);
    query(419, 108);
    chk("q_dead", 64'(enemy_on), 64'd0);
    op(0, 0, 1, 1, 1, 1, -1, -1);
    chk("tickhit_ack", 64'(hit_ack), 64'd1);
    chk("tickhit_x", 64'(origin_x), 64'd420);
    repeat (417) tick();
    chk("x_418", 64'(origin_x), 64'd837);
    tick();
    chk("rev_y", 64'(origin_y), 64'd140);
    chk("rev_x", 64'(origin_x), 64'd837);

    go();
    for (int r = 0; r < NR; r++) hit(r, 5);
    guard = 0;
    while (origin_y == 10'd108 && guard < 1000) begin
      tick();
      guard++;
    end
    chk("c5_rev_y", 64'(origin_y), 64'd140);
    chk("c5_rev_x", 64'(origin_x), 64'd919);

`ifdef ENEMY_SPEEDUP_EN
    go();
    for (int k = 0; k < 32; k++) hit(k / NC, k % NC);
    tick();
    chk("speed3_x", 64'(origin_x), 64'd422);
`endif

    go();
    for (int k = 0; k < 3000; k++) begin
      bit st, tk, hv;
      st = ($urandom_range(0, 999) < 3);
      tk = ($urandom_range(0, 1) == 1);
      hv = ($urandom_range(0, 9) < 4);
      op(0, st, tk, hv, int'($urandom_range(0, 11)),
         int'($urandom_range(0, 7)), -1, -1);
    end

    go();
    for (int k = 0; k < N; k++) hit(k / NC, k % NC);
    chk("clear_pulse", 64'(wave_clear), 64'd1);
    chk("clear_cnt", 64'(alive_count), 64'd0);
    tick();
    chk("clear_once", 64'(wave_clear), 64'd0);

    go();
    guard = 0;
    while (landed !== 1'b1 && guard < 8000) begin
      tick();
      guard++;
    end
    chk("landed", 64'(landed), 64'd1);
    chk("land_y", 64'(origin_y), 64'd268);
    repeat (20) tick();
    chk("land_sticky", 64'(landed), 64'd1);
    op(0, 1, 0, 1, 0, 0, -1, -1);
    chk("start_unland", 64'(landed), 64'd0);
    chk("start_drops_hit", 64'(hit_ack), 64'd0);
    chk("start_hit_cnt", 64'(alive_count), 64'd60);
    repeat (4) tick();

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
